// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter (with helper module shifter)
// Purpose  : Round-robin arbiter that shares one barrel shifter between m
//            requesters.
//            - One request is granted per cycle.
//            - The result goes to a one-entry registered response stage,
//              tagged with the index of the winning requester.
// Ports    : clk, rst          clock, synchronous active-high reset
//            req_valid[m]      per-requester request strobe
//            req_ready[m]      one-hot grant (combinational)
//            req_a[m*n]        operands, requester i at [i*n +: n]
//            req_b[m*clog2(n)] shift amounts
//            req_op[3*m]       {rot, left, sign} per requester
//            resp_valid/ready  response handshake
//            resp_out[n]       shift result
//            resp_id[clog2(m)] index of the requester that produced resp_out
//            stall_cnt[16]     saturating count of stalled response cycles
//                              (only with SHIFT_ARB_STALL_CNT_EN defined)
// Options  : SHIFT_ARB_STALL_CNT_EN adds the stall_cnt output and counter.
// Revision : 1.0  initial release
// ============================================================================

`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

// ----------------------------------------------------------------------------
// shifter: combinational barrel shifter.
//   op = {rot, left, sign}
//   rot=1          : rotate (left or right)
//   rot=0, left=1  : logical shift left
//   rot=0, left=0  : shift right (arithmetic when sign=1)
// ----------------------------------------------------------------------------
module shifter #(
  parameter int n = `DEFAULT_WIDTH
) (
  input  logic [n-1:0]         a,
  input  logic [$clog2(n)-1:0] b,
  input  logic [2:0]           op,
  output logic [n-1:0]         y
);
  logic [2*n-1:0] dbl_l;
  logic [2*n-1:0] dbl_r;

  always_comb begin
    // Rotations come from shifting the operand concatenated with itself.
    dbl_l = {a, a} << b;
    dbl_r = {a, a} >> b;
    y     = a;
    case (op[2:1])
      2'b11: y = dbl_l[2*n-1:n];
      2'b10: y = dbl_r[n-1:0];
      2'b01: y = a << b;
      default: begin
        // Kept outside a ternary so the signed operand keeps >>> arithmetic.
        if (op[0]) y = $signed(a) >>> b;
        else       y = a >> b;
      end
    endcase
  end
endmodule

module shift_arbiter #(
  parameter int n = `DEFAULT_WIDTH,
  parameter int m = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [m-1:0]             req_valid,
  output logic [m-1:0]             req_ready,
  input  logic [m*n-1:0]           req_a,
  input  logic [m*$clog2(n)-1:0]   req_b,
  input  logic [3*m-1:0]           req_op,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [n-1:0]             resp_out,
  output logic [$clog2(m)-1:0]     resp_id
`ifdef SHIFT_ARB_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);
  localparam int IDW = $clog2(m);
  localparam int BW  = $clog2(n);

  logic [n-1:0]   a_arr  [m];
  logic [BW-1:0]  b_arr  [m];
  logic [2:0]     op_arr [m];

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic           grant_any;
  logic           slot_free;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] ptr_next;
  logic [n-1:0]   shift_y;

  // Unpack the flat request buses into per-requester arrays.
  for (genvar i = 0; i < m; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*n +: n];
    assign b_arr[i]  = req_b[i*BW +: BW];
    assign op_arr[i] = req_op[3*i +: 3];
  end

  assign slot_free = !resp_valid || resp_ready;

  // Scan ptr, ptr+1, ... (mod m) and keep the first valid requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < m; k++) begin
      scan_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(m)) scan_sum = scan_sum - (IDW+1)'(m);
      scan_idx = scan_sum[IDW-1:0];
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Nothing is accepted while in reset, so the grant is masked with rst.
  assign grant_any = slot_free && gnt_found && !rst;
  assign req_ready = grant_any ? ({{(m-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign ptr_next  = (gnt_idx == IDW'(m-1)) ? '0 : gnt_idx + 1'b1;

  shifter #(.n(n)) u_shifter (
    .a  (a_arr[gnt_idx]),
    .b  (b_arr[gnt_idx]),
    .op (op_arr[gnt_idx]),
    .y  (shift_y)
  );

  // A grant always reloads the slot, which also covers drain-and-refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      resp_valid <= 1'b0;
      resp_out   <= '0;
      resp_id    <= '0;
    end else if (grant_any) begin
      ptr        <= ptr_next;
      resp_valid <= 1'b1;
      resp_out   <= shift_y;
      resp_id    <= gnt_idx;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef SHIFT_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (resp_valid && !resp_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Purpose  : Directed bench for shift_arbiter with n=8, m=4.
//            - Covers reset, every shift operation and round-robin order.
//            - Covers backpressure and drain-and-refill, then a mid-stream
//              reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_arbiter;
  localparam int N = 8;
  localparam int M = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [M-1:0]  req_valid;
  logic [M-1:0]  req_ready;
  logic [M*N-1:0] req_a;
  logic [M*3-1:0] req_b;
  logic [3*M-1:0] req_op;
  logic          resp_valid;
  logic          resp_ready;
  logic [N-1:0]  resp_out;
  logic [1:0]    resp_id;
`ifdef SHIFT_ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  shift_arbiter #(.n(N), .m(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .resp_id    (resp_id)
`ifdef SHIFT_ARB_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [2:0] b,
                         input logic [2:0] op);
    req_a[i*N +: N] = a;
    req_b[i*3 +: 3] = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-request vectors: requester, a, b, op, expected result
  int          v_id  [5] = '{2, 3, 0, 1, 2};
  logic [2:0]  v_b   [5] = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd2};
  logic [2:0]  v_op  [5] = '{3'b100, 3'b010, 3'b001, 3'b111, 3'b000};
  logic [7:0]  v_exp [5] = '{8'b11000011, 8'b00001110, 8'b11100001,
                             8'b10000111, 8'b00100001};
  int          rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst        = 1'b1;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    step();
    step();
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_resp_out", 32'(resp_out), 32'h0);
    chk("reset_resp_id", 32'(resp_id), 32'h0);

    // Single request: rotate left by 3 from requester 1
    rst       = 1'b0;
    req_valid = 4'b0010;
    set_req(1, 8'b10000111, 3'd3, 3'b110);
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h2);
    step();
    chk("single_resp_valid", 32'(resp_valid), 32'h1);
    chk("single_resp_out", 32'(resp_out), 32'h3C);
    chk("single_resp_id", 32'(resp_id), 32'h1);

    // Operation coverage, back to back
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b0001 << v_id[k];
      set_req(v_id[k], 8'b10000111, v_b[k], v_op[k]);
      step();
      chk($sformatf("op%0d_out", k), 32'(resp_out), 32'(v_exp[k]));
      chk($sformatf("op%0d_id", k), 32'(resp_id), 32'(v_id[k]));
    end
    req_valid = 4'b0000;
    step();
    chk("drain_resp_valid", 32'(resp_valid), 32'h0);

    // Round robin from reset with all requesters valid
    rst = 1'b1;
    for (int i = 0; i < M; i++) set_req(i, 8'(8'h10 + i), 3'd0, 3'b000);
    step();
    rst       = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(4'b0001 << rr_exp[k]));
      step();
      chk($sformatf("rr%0d_id", k), 32'(resp_id), 32'(rr_exp[k]));
      chk($sformatf("rr%0d_out", k), 32'(resp_out), 32'(8'h10 + rr_exp[k]));
    end

    // Backpressure for three cycles: outputs frozen, nothing accepted
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
      step();
      chk($sformatf("bp%0d_valid", k), 32'(resp_valid), 32'h1);
      chk($sformatf("bp%0d_id", k), 32'(resp_id), 32'h1);
      chk($sformatf("bp%0d_out", k), 32'(resp_out), 32'h11);
    end
`ifdef SHIFT_ARB_STALL_CNT_EN
    chk("bp_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

    // Drain and refill in the same cycle
    resp_ready = 1'b1;
    #1;
    chk("refill_ready", 32'(req_ready), 32'h4);
    step();
    chk("refill_valid", 32'(resp_valid), 32'h1);
    chk("refill_id", 32'(resp_id), 32'h2);
    chk("refill_out", 32'(resp_out), 32'h12);

    // Reset mid-stream with a response held and requests pending
    resp_ready = 1'b0;
    rst        = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    step();
    chk("midrst_valid", 32'(resp_valid), 32'h0);
    chk("midrst_id", 32'(resp_id), 32'h0);
    chk("midrst_out", 32'(resp_out), 32'h0);
`ifdef SHIFT_ARB_STALL_CNT_EN
    chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst        = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 4'b0110;
    #1;
    chk("postrst_ready", 32'(req_ready), 32'h2);
    step();
    chk("postrst_id", 32'(resp_id), 32'h1);
    chk("postrst_out", 32'(resp_out), 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
# shift_arbiter

Shares a single `shifter` barrel-shifter instance between `m` requesters using round-robin arbitration. Each requester presents an operand, a shift amount and an operation over a valid/ready handshake. The block grants one request per cycle and returns the result with the winning requester's index through a one-entry registered response stage. It sits between the execution-unit issue logic and the shared shift datapath, replacing per-unit shifters.

## Interface
Parameters:
- `n`, `` `DEFAULT_WIDTH ``: data width; power of two, ≥ 2.
- `m`, 4: number of requesters; ≥ 2.

Ports (`$clog2` below written as clog2). Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req_valid`  input  m  bit i: requester i has a request.
- `req_ready`  output  m  bit i: request i accepted this cycle; one-hot or zero.
- `req_a`  input  m·n  operand; requester i at bits [i·n +: n].
- `req_b`  input  m·clog2(n)  shift amount; requester i at [i·clog2(n) +: clog2(n)].
- `req_op`  input  3·m  requester i at [3i +: 3] = {rot, left, sign}; same meaning as on `shifter`.
- `resp_valid`  output  1  response register holds a result.
- `resp_ready`  input  1  consumer accepts the response.
- `resp_out`  output  n  shift result.
- `resp_id`  output  clog2(m)  index of the requester that produced `resp_out`.

## Operation
- Internal state: round-robin pointer `ptr` (clog2(m) bits), response register {`resp_valid`, `resp_out`, `resp_id`}.
- `slot_free = !resp_valid || resp_ready`.
- Grant: if `slot_free`, grant the first i with `req_valid[i]=1`, scanning `ptr`, `ptr+1`, …, wrapping mod m. Otherwise no grant. `req_ready` is the one-hot grant vector.
- `req_ready` is combinational from `req_valid`, `resp_valid`, `resp_ready` and `ptr`. Requesters must not make `req_valid` depend on `req_ready`.
- The granted request's `req_a`/`req_b`/`req_op` are muxed into one `shifter #(n)`. The shifter output is captured into `resp_out`, and the grant index into `resp_id`.
- On a grant of index g: `ptr <= (g+1) mod m`. When there is no grant, `ptr` holds.
- Response register update:
  - Grant: load the new result and set `resp_valid=1`. This also covers the simultaneous drain-and-refill case.
  - No grant and `resp_ready=1`: `resp_valid <= 0`.
  - Otherwise: hold all response fields stable.
- Requesters hold their request until `req_ready`. The block never drops or reorders an accepted request.
- Reset values: `resp_valid=0`, `resp_out=0`, `resp_id=0`, `ptr=0`. `req_ready=0` during the reset cycle.
- Reset mid-operation discards any held response, with no partial output.

## Timing
- Latency: accepted in cycle T, `resp_valid` and result visible in T+1.
- Throughput: one request per cycle while `resp_ready=1`.
- Backpressure: while `resp_valid=1` and `resp_ready=0`, `req_ready=0` and the outputs are frozen.
- Fairness: with all requesters continuously valid, each is granted once per m consecutive grants.

## Configuration
- `SHIFT_ARB_STALL_CNT_EN` defined: adds output port `stall_cnt` [15:0].
  - Increments each cycle with `resp_valid=1` and `resp_ready=0`.
  - Saturates at 16'hFFFF.
  - Resets to 0 on `rst`.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
Bench uses n=8, m=4.
- Single request, rol: requester 1, a=8'b10000111, b=3, op={1,1,0} → next cycle `resp_valid=1`, `resp_out`=8'b00111100, `resp_id`=1.
- Op coverage on a=8'b10000111:
  - ror b=1 → 8'b11000011.
  - lsl b=1, sign=0 → 8'b00001110.
  - lsr b=2, sign=1 → 8'b11100001.
  - b=0 with any op → 8'b10000111.
- Round-robin: all 4 valid continuously, `resp_ready=1` from reset → `resp_id` sequence 0,1,2,3,0,1; one grant per cycle.
- Backpressure: hold `resp_ready=0` for 3 cycles while all requesters are valid → `req_ready`=4'b0000, `resp_out`/`resp_id` stable. With the macro defined, `stall_cnt`=3. Raising `resp_ready` produces a drain-and-refill in the same cycle with no bubble.
- Reset mid-stream: assert `rst` while `resp_valid=1` and requests are pending → next cycle `resp_valid=0`, `resp_id=0`. The first post-reset grant goes to the lowest-index valid requester.
